// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU and the wide sequencer that drives it.
// ALU function encodings, sequencer states and the ALU slice width.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_fun_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  // Arithmetic ops chain carry between slices; logic ops pass cin straight through.
  function automatic logic is_arith(input alu_fun_t f);
    return (f == ALU_ADD) || (f == ALU_SUB);
  endfunction

endpackage

// File: rtl/wide_alu_seq.sv
// Wide-operand sequencer: walks an external 8-bit ALU over N_BYTES slices, LSB first,
// chaining carry and accumulating zero, then holds the wide result for a valid/ready consumer.
module wide_alu_seq
  import alu_pkg::*;
#(
  parameter int N_BYTES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic [ALU_W*N_BYTES-1:0]   a,
  input  logic [ALU_W*N_BYTES-1:0]   b,
  input  logic                       cin,
  output logic [1:0]                 alu_fun,
  output logic [ALU_W-1:0]           alu_a,
  output logic [ALU_W-1:0]           alu_b,
  output logic                       alu_cin,
  input  logic [ALU_W-1:0]           alu_out,
  input  logic                       alu_cout,
  input  logic                       alu_zero,
  input  logic                       alu_negetive,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ALU_W*N_BYTES-1:0]   res,
  output logic                       res_cout,
  output logic                       res_zero,
  output logic                       res_negative
);

  localparam int SW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_BYTES - 1);

  seq_state_t state, nstate;
  logic [SW-1:0] slice;

  logic [N_BYTES-1:0][ALU_W-1:0] a_q, b_q, res_q;
  alu_fun_t op_q;
  logic     cin_q;
  logic     carry_q;
  logic     zacc_q;
  logic     cout_q, zero_q, neg_q;

  logic accept, last, first;

  assign accept = in_valid && in_ready;
  assign last   = (slice == LAST);
  assign first  = (slice == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept)    nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    if (res_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  // Handshake outputs and ALU drive, all decoded from registered state
  always_comb begin
    in_ready  = (state == IDLE);
    res_valid = (state == DONE);
    alu_fun   = ALU_ADD;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    if (state == RUN) begin
      alu_a = a_q[slice];
      unique case (op_q)
        ALU_ADD: begin
          alu_b   = b_q[slice];
          alu_cin = first ? cin_q : carry_q;
        end
        // a - b as a + ~b + 1; the ALU's own subtract is never used so borrow chains cleanly
        ALU_SUB: begin
          alu_b   = ~b_q[slice];
          alu_cin = first ? 1'b1 : carry_q;
        end
        default: begin
          alu_fun = op_q;
          alu_b   = b_q[slice];
          alu_cin = cin_q;
        end
      endcase
    end
  end

  // Operand capture and per-slice result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      slice   <= '0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= alu_fun_t'(op);
      a_q     <= a;
      b_q     <= b;
      cin_q   <= cin;
      slice   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
    end else if (state == RUN) begin
      res_q[slice] <= alu_out;
      carry_q      <= alu_cout;
      zacc_q       <= zacc_q & alu_zero;
      if (last) begin
        cout_q <= alu_cout;
        neg_q  <= alu_negetive;
        zero_q <= zacc_q & alu_zero;
      end else begin
        slice <= slice + 1'b1;
      end
    end
  end

  assign res          = res_q;
  assign res_cout     = cout_q;
  assign res_zero     = zero_q;
  assign res_negative = neg_q;

  // Logic ops never consume the inter-slice carry; keep the helper visible to readers of op_q
  logic unused_arith;
  assign unused_arith = is_arith(op_q);

endmodule
